// File: rtl/adc_acq_pkg.sv
// Shared types and default widths for the ADC capture/serialise block.
// FSM states and default channel geometry.
package adc_acq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_PARITY,
    ST_DONE
  } acq_state_e;

  localparam int DATA_W_DEF   = 14;
  localparam int CHANNELS_DEF = 1;

endpackage

// File: rtl/adc_acq_fifo.sv
// Synchronous frame FIFO with occupancy count.
// A write on a full FIFO is accepted only if a read happens in the same cycle.
module adc_acq_fifo #(
  parameter int W     = 28,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          wr_ok, rd_ok;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign rd_data = mem_q[rptr_q];
  assign wr_ok   = wr && (!full || rd);
  assign rd_ok   = rd && !empty;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (wr_ok) begin
      mem_d[wptr_q] = wr_data;
      wptr_d        = wptr_q + 1'b1;
    end
    if (rd_ok) begin
      rptr_d = rptr_q + 1'b1;
    end
    unique case ({wr_ok, rd_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_acq_serializer.sv
// Multi-channel ADC capture, frame FIFO and MSB-first serialiser.
// Define ADC_ACQ_PARITY_EN to append an even-parity bit to every frame.
module adc_acq_serializer
  import adc_acq_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int CHANNELS   = CHANNELS_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int BIT_DIV    = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CHANNELS*DATA_W-1:0]     adc_d,
  input  logic                           adc_rd_n,
  input  logic                           ovf_clr,
  output logic                           ser_dout,
  output logic                           ser_clk,
  output logic                           ser_frame,
  output logic                           empty_tick,
  output logic                           overflow,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);

  localparam int FRAME_W = CHANNELS * DATA_W;
  localparam int BC_W    = $clog2(FRAME_W);
  localparam int DC_W    = $clog2(BIT_DIV);

  acq_state_e         state_q, state_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DC_W-1:0]    div_cnt_q, div_cnt_d;
  logic               rd_n_q, rd_n_d;
  logic               ovf_q, ovf_d;
  logic               capture, pop;
  logic               fifo_full, fifo_empty;
  logic [FRAME_W-1:0] fifo_rd_data;
  logic               bit_end;
`ifdef ADC_ACQ_PARITY_EN
  logic               par_q, par_d;
`endif

  assign rd_n_d  = adc_rd_n;
  assign capture = rd_n_q && !adc_rd_n;
  assign bit_end = (div_cnt_q == DC_W'(BIT_DIV-1));

  adc_acq_fifo #(
    .W     (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (capture),
    .wr_data (adc_d),
    .rd      (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    ovf_d = ovf_q;
    if (capture && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // IDLE also reacts to the capture itself so the frame loads one cycle later.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    pop       = 1'b0;
`ifdef ADC_ACQ_PARITY_EN
    par_d     = par_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty || capture) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        pop       = 1'b1;
        shreg_d   = fifo_rd_data;
        bit_cnt_d = BC_W'(FRAME_W-1);
        div_cnt_d = '0;
`ifdef ADC_ACQ_PARITY_EN
        par_d     = ^fifo_rd_data;
`endif
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bit_end) begin
          div_cnt_d = '0;
          if (bit_cnt_q == '0) begin
`ifdef ADC_ACQ_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_DONE;
`endif
          end else begin
            shreg_d   = {shreg_q[FRAME_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
`ifdef ADC_ACQ_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          div_cnt_d = '0;
          state_d   = ST_DONE;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
`endif
      ST_DONE: begin
        state_d = fifo_empty ? ST_IDLE : ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ser_frame  = (state_q == ST_SHIFT) || (state_q == ST_PARITY);
    ser_clk    = ser_frame && (div_cnt_q >= DC_W'(BIT_DIV/2));
    empty_tick = (state_q == ST_DONE) && fifo_empty;
    ser_dout   = 1'b0;
    if (state_q == ST_SHIFT) ser_dout = shreg_q[FRAME_W-1];
`ifdef ADC_ACQ_PARITY_EN
    if (state_q == ST_PARITY) ser_dout = par_q;
`endif
  end

  assign overflow = ovf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      rd_n_q    <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      rd_n_q    <= rd_n_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef ADC_ACQ_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) par_q <= 1'b0;
    else        par_q <= par_d;
  end
`endif

endmodule

// File: tb/tb_adc_acq_serializer.sv
// Directed bench for adc_acq_serializer with a frame scoreboard.
// Honours ADC_ACQ_PARITY_EN when computing expected frames.
module tb_adc_acq_serializer;

  localparam int DW = 14;
  localparam int CH = 2;
  localparam int FD = 4;
  localparam int BD = 4;
  localparam int FW = DW * CH;
`ifdef ADC_ACQ_PARITY_EN
  localparam int NB = FW + 1;
`else
  localparam int NB = FW;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [FW-1:0] adc_d = '0;
  logic          adc_rd_n = 1'b1;
  logic          ovf_clr = 1'b0;
  logic          ser_dout, ser_clk, ser_frame, empty_tick, overflow;
  logic [2:0]    fifo_level;

  int vecs = 0;
  int errs = 0;
  int frames = 0;
  int ticks = 0;
  logic [63:0] exp_q [$];

  adc_acq_serializer #(
    .DATA_W     (DW),
    .CHANNELS   (CH),
    .FIFO_DEPTH (FD),
    .BIT_DIV    (BD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .adc_d      (adc_d),
    .adc_rd_n   (adc_rd_n),
    .ovf_clr    (ovf_clr),
    .ser_dout   (ser_dout),
    .ser_clk    (ser_clk),
    .ser_frame  (ser_frame),
    .empty_tick (empty_tick),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] exp_bits(input logic [FW-1:0] d);
`ifdef ADC_ACQ_PARITY_EN
    return {35'b0, d, ^d};
`else
    return {36'b0, d};
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [FW-1:0] d, input bit push,
                        input logic clr);
    adc_d    = d;
    adc_rd_n = 1'b0;
    ovf_clr  = clr;
    if (push) exp_q.push_back(exp_bits(d));
    step(1);
    adc_rd_n = 1'b1;
    ovf_clr  = 1'b0;
    step(2);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || ser_frame || fifo_level != 0)
           && n < 3000) begin
      step(1);
      n++;
    end
    check({tag, "_timeout"}, 64'(n < 3000), 64'd1);
    step(4);
  endtask

  // Monitor: assemble bits on rising ser_clk, score at ser_frame fall.
  logic        prev_f = 1'b0;
  logic        prev_c = 1'b0;
  logic [63:0] acc = '0;
  int          nb = 0;
  int          cyc = 0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_f = 1'b0;
      prev_c = 1'b0;
      acc    = '0;
      nb     = 0;
      cyc    = 0;
    end else begin
      if (empty_tick) ticks++;
      if (ser_frame) begin
        cyc++;
        if (ser_clk && !prev_c) begin
          acc = {acc[62:0], ser_dout};
          nb++;
        end
      end else if (prev_f) begin
        frames++;
        check("frame_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("frame_bits", acc, e);
          check("frame_nbits", 64'(nb), 64'(NB));
          check("frame_cycles", 64'(cyc), 64'(NB * BD));
        end
        acc = '0;
        nb  = 0;
        cyc = 0;
      end
      prev_f = ser_frame;
      prev_c = ser_clk;
    end
  end

  initial begin
    int f0, t0, maxlvl;
    logic [FW-1:0] d;

    step(3);
    check("rst_outputs",
          64'({ser_dout, ser_clk, ser_frame, empty_tick, overflow,
               fifo_level}), 64'd0);
    reset = 1'b1;
    step(2);

    // 1: single strobe, latency and bit order
    t0 = ticks;
    f0 = frames;
    d = {14'h2A5B, 14'h1234};
    adc_d    = d;
    adc_rd_n = 1'b0;
    exp_q.push_back(exp_bits(d));
    step(1);
    adc_rd_n = 1'b1;
    check("t1_load_no_frame", 64'(ser_frame), 64'd0);
    step(1);
    check("t1_first_bit_frame", 64'(ser_frame), 64'd1);
    check("t1_first_bit_msb", 64'(ser_dout), 64'(d[FW-1]));
    wait_done("t1");
    check("t1_frames", 64'(frames - f0), 64'd1);
    check("t1_ticks", 64'(ticks - t0), 64'd1);

    // 2: strobe held low for 50 cycles
    t0 = ticks;
    f0 = frames;
    maxlvl = 0;
    d = {14'h0ABC, 14'h3001};
    adc_d    = d;
    adc_rd_n = 1'b0;
    exp_q.push_back(exp_bits(d));
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
    end
    adc_rd_n = 1'b1;
    wait_done("t2");
    check("t2_frames", 64'(frames - f0), 64'd1);
    check("t2_max_level", 64'(maxlvl), 64'd1);
    check("t2_ticks", 64'(ticks - t0), 64'd1);

    // 3: six strobes, sixth dropped on full FIFO
    t0 = ticks;
    f0 = frames;
    for (int i = 0; i < 6; i++) begin
      d = {14'(i * 37 + 5), 14'(i * 1000 + 3)};
      strobe(d, i < 5, 1'b0);
    end
    check("t3_level_full", 64'(fifo_level), 64'(FD));
    check("t3_overflow", 64'(overflow), 64'd1);
    wait_done("t3");
    check("t3_frames", 64'(frames - f0), 64'd5);
    check("t3_ticks", 64'(ticks - t0), 64'd1);

    // 5: clear on overflowing capture keeps overflow set
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("t5_cleared", 64'(overflow), 64'd0);
    for (int i = 0; i < 6; i++) begin
      d = {14'(i * 91 + 7), 14'(16383 - i)};
      strobe(d, i < 5, i == 5);
    end
    check("t5_set_wins", 64'(overflow), 64'd1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("t5_lone_clear", 64'(overflow), 64'd0);
    wait_done("t5");

    // 4: reset mid-frame
    strobe({14'h1111, 14'h2222}, 1'b0, 1'b0);
    strobe({14'h3333, 14'h0444}, 1'b0, 1'b0);
    step(30);
    check("t4_midframe", 64'(ser_frame), 64'd1);
    check("t4_level_pre", 64'(fifo_level), 64'd1);
    reset = 1'b0;
    #1;
    check("t4_rst_outputs",
          64'({ser_dout, ser_clk, ser_frame, empty_tick, overflow,
               fifo_level}), 64'd0);
    step(2);
    t0 = ticks;
    f0 = frames;
    reset = 1'b1;
    step(300);
    check("t4_no_tick", 64'(ticks - t0), 64'd0);
    check("t4_no_frame", 64'(frames - f0), 64'd0);

    // 6: parity-sensitive frame
    t0 = ticks;
    d = {14'h3FFF, 14'h0001};
    strobe(d, 1'b1, 1'b0);
    wait_done("t6");
    check("t6_ticks", 64'(ticks - t0), 64'd1);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
